f1_ls_fwd: RTL and testbench

//  Forward LS transform of GOST R 34.12-2015 (Kuznyechik), encryption direction.
//  - Applies the nonlinear substitution S (pi table) to all 16 bytes in one cycle.
//  - Then applies the linear transform L = R^16 as 16 iterative R steps, one per clock.
//  - Sits in the round datapath next to the inverse-LS block; uses the same valid/pre_ready/ready strobe interface.

---
 rtl/f1_ls_fwd_if.sv | 29 ++
 rtl/f1_ls_fwd.sv | 126 ++++++++++++
 tb/tb_f1_ls_fwd.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/f1_ls_fwd_if.sv
// f1_ls_fwd_if: strobe/data bundle of the forward LS block.
// F1_LS_L_ONLY_EN adds the l_only_s mode input.
interface f1_ls_fwd_if;
    logic             valid_s;
    logic [15:0][7:0] din;
    logic             busy_s;
    logic             pre_ready_s;
    logic             ready_s;
    logic [15:0][7:0] dout;
`ifdef F1_LS_L_ONLY_EN
    logic             l_only_s;
`endif

    modport master (
        output valid_s, din,
`ifdef F1_LS_L_ONLY_EN
        output l_only_s,
`endif
        input  busy_s, pre_ready_s, ready_s, dout
    );

    modport slave (
        input  valid_s, din,
`ifdef F1_LS_L_ONLY_EN
        input  l_only_s,
`endif
        output busy_s, pre_ready_s, ready_s, dout
    );
endinterface

// File: rtl/f1_ls_fwd.sv
// f1_ls_fwd: Kuznyechik forward LS (pi substitution, then 16 serial R steps over GF(2^8) mod 0x1C3).
// F1_LS_L_ONLY_EN adds l_only_s, which bypasses the substitution so dout = L(din).
module f1_ls_fwd (
    input logic        clk,
    input logic        reset,
    f1_ls_fwd_if.slave bus
);
    typedef enum logic [1:0] {IDLE, SUB, ROUND} state_t;

    localparam logic [7:0] PI [256] = '{
        8'd252, 8'd238, 8'd221, 8'd17,  8'd207, 8'd110, 8'd49,  8'd22,  8'd251, 8'd196, 8'd250, 8'd218, 8'd35,  8'd197, 8'd4,   8'd77,
        8'd233, 8'd119, 8'd240, 8'd219, 8'd147, 8'd46,  8'd153, 8'd186, 8'd23,  8'd54,  8'd241, 8'd187, 8'd20,  8'd205, 8'd95,  8'd193,
        8'd249, 8'd24,  8'd101, 8'd90,  8'd226, 8'd92,  8'd239, 8'd33,  8'd129, 8'd28,  8'd60,  8'd66,  8'd139, 8'd1,   8'd142, 8'd79,
        8'd5,   8'd132, 8'd2,   8'd174, 8'd227, 8'd106, 8'd143, 8'd160, 8'd6,   8'd11,  8'd237, 8'd152, 8'd127, 8'd212, 8'd211, 8'd31,
        8'd235, 8'd52,  8'd44,  8'd81,  8'd234, 8'd200, 8'd72,  8'd171, 8'd242, 8'd42,  8'd104, 8'd162, 8'd253, 8'd58,  8'd206, 8'd204,
        8'd181, 8'd112, 8'd14,  8'd86,  8'd8,   8'd12,  8'd118, 8'd18,  8'd191, 8'd114, 8'd19,  8'd71,  8'd156, 8'd183, 8'd93,  8'd135,
        8'd21,  8'd161, 8'd150, 8'd41,  8'd16,  8'd123, 8'd154, 8'd199, 8'd243, 8'd145, 8'd120, 8'd111, 8'd157, 8'd158, 8'd178, 8'd177,
        8'd50,  8'd117, 8'd25,  8'd61,  8'd255, 8'd53,  8'd138, 8'd126, 8'd109, 8'd84,  8'd198, 8'd128, 8'd195, 8'd189, 8'd13,  8'd87,
        8'd223, 8'd245, 8'd36,  8'd169, 8'd62,  8'd168, 8'd67,  8'd201, 8'd215, 8'd121, 8'd214, 8'd246, 8'd124, 8'd34,  8'd185, 8'd3,
        8'd224, 8'd15,  8'd236, 8'd222, 8'd122, 8'd148, 8'd176, 8'd188, 8'd220, 8'd232, 8'd40,  8'd80,  8'd78,  8'd51,  8'd10,  8'd74,
        8'd167, 8'd151, 8'd96,  8'd115, 8'd30,  8'd0,   8'd98,  8'd68,  8'd26,  8'd184, 8'd56,  8'd130, 8'd100, 8'd159, 8'd38,  8'd65,
        8'd173, 8'd69,  8'd70,  8'd146, 8'd39,  8'd94,  8'd85,  8'd47,  8'd140, 8'd163, 8'd165, 8'd125, 8'd105, 8'd213, 8'd149, 8'd59,
        8'd7,   8'd88,  8'd179, 8'd64,  8'd134, 8'd172, 8'd29,  8'd247, 8'd48,  8'd55,  8'd107, 8'd228, 8'd136, 8'd217, 8'd231, 8'd137,
        8'd225, 8'd27,  8'd131, 8'd73,  8'd76,  8'd63,  8'd248, 8'd254, 8'd141, 8'd83,  8'd170, 8'd144, 8'd202, 8'd216, 8'd133, 8'd97,
        8'd32,  8'd113, 8'd103, 8'd164, 8'd45,  8'd43,  8'd9,   8'd91,  8'd203, 8'd155, 8'd37,  8'd208, 8'd190, 8'd229, 8'd108, 8'd82,
        8'd89,  8'd166, 8'd116, 8'd210, 8'd230, 8'd244, 8'd180, 8'd192, 8'd209, 8'd102, 8'd175, 8'd194, 8'd57,  8'd75,  8'd99,  8'd182
    };

    // indexed by byte position: LC[i] multiplies a(i)
    localparam logic [7:0] LC [16] = '{
        8'd1, 8'd148, 8'd32, 8'd133, 8'd16, 8'd194, 8'd192, 8'd1,
        8'd251, 8'd1, 8'd192, 8'd194, 8'd16, 8'd133, 8'd32, 8'd148
    };

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            p = b[i] ? p ^ x : p;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'hc3 : 8'h00);
        end
        return p;
    endfunction

    state_t           state;
    logic [3:0]       rcnt;
    logic [15:0][7:0] din_r;
    logic [15:0][7:0] work_r;
    logic [15:0][7:0] dout_r;
    logic [15:0][7:0] sub_w;
    logic [15:0][7:0] r_w;
    logic [7:0]       l_w;
    logic             busy_r;
    logic             pre_r;
    logic             rdy_r;
`ifdef F1_LS_L_ONLY_EN
    logic             l_only_r;
`endif

    always_comb begin
        l_w = 8'h00;
        for (int i = 0; i < 16; i++) begin
            l_w = l_w ^ gf_mul(work_r[i], LC[i]);
`ifdef F1_LS_L_ONLY_EN
            sub_w[i] = l_only_r ? din_r[i] : PI[din_r[i]];
`else
            sub_w[i] = PI[din_r[i]];
`endif
        end
        r_w = {l_w, work_r[15:1]};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            rcnt   <= 4'd0;
            din_r  <= '0;
            work_r <= '0;
            dout_r <= '0;
            busy_r <= 1'b0;
            pre_r  <= 1'b0;
            rdy_r  <= 1'b0;
`ifdef F1_LS_L_ONLY_EN
            l_only_r <= 1'b0;
`endif
        end else begin
            pre_r <= 1'b0;
            rdy_r <= 1'b0;
            case (state)
                IDLE: if (bus.valid_s) begin
                    din_r  <= bus.din;
`ifdef F1_LS_L_ONLY_EN
                    l_only_r <= bus.l_only_s;
`endif
                    busy_r <= 1'b1;
                    state  <= SUB;
                end
                SUB: begin
                    work_r <= sub_w;
                    rcnt   <= 4'd0;
                    state  <= ROUND;
                end
                ROUND: begin
                    rcnt  <= rcnt + 4'd1;
                    pre_r <= rcnt == 4'd14;
                    if (rcnt == 4'd15) begin
                        dout_r <= r_w;
                        rdy_r  <= 1'b1;
                        busy_r <= 1'b0;
                        state  <= IDLE;
                    end else begin
                        work_r <= r_w;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.busy_s      = busy_r;
    assign bus.pre_ready_s = pre_r;
    assign bus.ready_s     = rdy_r;
    assign bus.dout        = dout_r;
endmodule

// File: tb/tb_f1_ls_fwd.sv
// tb_f1_ls_fwd: scoreboard bench for f1_ls_fwd; expected results and due cycles are queued at accept
// and popped by an independent monitor on every ready_s pulse.
module tb_f1_ls_fwd;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    logic prev_pre = 1'b0;
    logic [127:0] exp_q [$];
    int           due_q [$];

    f1_ls_fwd_if bus ();
    f1_ls_fwd dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    localparam logic [127:0] V_KNOWN_IN  = 128'hacba95a5a5a5a5a5a5a5a5a5a5a5a5a5;
    localparam logic [127:0] V_KNOWN_OUT = 128'hd456584dd0e3e84cc3166e4b7fa2890d;
    localparam logic [127:0] V_FULL_IN   = 128'hffeeddccbbaa99881122334455667700;
    localparam logic [127:0] V_FULL_S    = 128'hb66cd8887d38e8d77765aeea0c9a7efc;
    localparam logic [127:0] V_ZERO_IN   = 128'ha5a5a5a5a5a5a5a5a5a5a5a5a5a5a5a5;
    localparam logic [127:0] V_FC_S      = {16{8'hfc}};

    function automatic logic [7:0] gm(input logic [7:0] a, input int k);
        int r;
        int aa;
        r = 0;
        aa = a;
        for (int b = 0; b < 8; b++) begin
            if (((k >> b) & 1) != 0) r = r ^ aa;
            aa = aa << 1;
            if ((aa & 'h100) != 0) aa = aa ^ 'h1c3;
        end
        return r[7:0];
    endfunction

    function automatic logic [127:0] l_ref(input logic [127:0] v);
        int c [16];
        logic [127:0] t;
        logic [7:0] l;
        c = '{148, 32, 133, 16, 194, 192, 1, 251, 1, 192, 194, 16, 133, 32, 148, 1};
        t = v;
        for (int n = 0; n < 16; n++) begin
            l = 8'h00;
            for (int j = 0; j < 16; j++) l = l ^ gm(t[127 - 8*j -: 8], c[j]);
            t = {l, t[127:8]};
        end
        return t;
    endfunction

    task automatic chk(input string name, input logic [127:0] got, input logic [127:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s got=%h want=%h", name, got, want);
        end
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            if (bus.ready_s) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_ready", 128'd1, 128'd0);
                end else begin
                    logic [127:0] e;
                    int d;
                    e = exp_q.pop_front();
                    d = due_q.pop_front();
                    chk("dout", bus.dout, e);
                    chk("latency_cycle", 128'(cyc), 128'(d));
                    chk("pre_before_ready", 128'(prev_pre), 128'd1);
                end
            end else if (prev_pre) begin
                chk("pre_without_ready", 128'd0, 128'd1);
            end
        end
        prev_pre = bus.pre_ready_s;
    end

    task automatic wait_idle();
        int n;
        n = 0;
        while (bus.busy_s && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (bus.busy_s) chk("idle_timeout", 128'd1, 128'd0);
    endtask

    task automatic send(input logic [127:0] d, input logic lo, input logic [127:0] e);
        @(negedge clk);
        wait_idle();
        bus.valid_s = 1'b1;
        bus.din = d;
`ifdef F1_LS_L_ONLY_EN
        bus.l_only_s = lo;
`else
        if (lo) $display("note: l_only request ignored in this build");
`endif
        @(posedge clk);
        #1;
        bus.valid_s = 1'b0;
        exp_q.push_back(e);
        due_q.push_back(cyc + 17);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0) chk("drain_timeout", 128'(exp_q.size()), 128'd0);
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout got=%0d want=done", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        bus.valid_s = 1'b0;
        bus.din = '0;
`ifdef F1_LS_L_ONLY_EN
        bus.l_only_s = 1'b0;
`endif
        repeat (3) @(negedge clk);
        chk("reset_dout", bus.dout, 128'd0);
        chk("reset_flags", {bus.busy_s, bus.pre_ready_s, bus.ready_s}, 128'd0);
        reset = 1'b0;
        @(negedge clk);

        send(V_KNOWN_IN, 1'b0, V_KNOWN_OUT);
        drain();
        send(V_FULL_IN, 1'b0, l_ref(V_FULL_S));
        drain();
        send(V_ZERO_IN, 1'b0, 128'd0);
        drain();
        send(128'd0, 1'b0, l_ref(V_FC_S));
        drain();
`ifdef F1_LS_L_ONLY_EN
        send(128'h64a59400000000000000000000000000, 1'b1, V_KNOWN_OUT);
        drain();
        send(V_KNOWN_OUT, 1'b1, 128'h79d26221b87b584cd42fbc4ffea5de9a);
        drain();
        for (int k = 0; k < 8; k++) begin
            logic [127:0] r;
            r = {$urandom, $urandom, $urandom, $urandom};
            send(r, 1'b1, l_ref(r));
            drain();
        end
        bus.l_only_s = 1'b0;
`endif

        // busy ignore: second request lands at E5
        send(128'd0, 1'b0, l_ref(V_FC_S));
        for (int k = 1; k <= 17; k++) begin
            @(negedge clk);
            chk("busy_in_flight", 128'(bus.busy_s), 128'd1);
            if (k == 5) begin
                bus.valid_s = 1'b1;
                bus.din = V_KNOWN_IN;
            end
            if (k == 6) bus.valid_s = 1'b0;
        end
        drain();

        // back-to-back with valid_s held high
        begin
            int c0;
            @(negedge clk);
            bus.valid_s = 1'b1;
            bus.din = V_KNOWN_IN;
            @(posedge clk);
            #1;
            c0 = cyc;
            exp_q.push_back(V_KNOWN_OUT);     due_q.push_back(c0 + 17);
            exp_q.push_back(l_ref(V_FULL_S)); due_q.push_back(c0 + 35);
            exp_q.push_back(128'd0);          due_q.push_back(c0 + 53);
            @(negedge clk);
            bus.din = V_FULL_IN;
            repeat (18) @(posedge clk);
            #1;
            chk("b2b_second_accept", 128'(bus.busy_s), 128'd1);
            @(negedge clk);
            bus.din = V_ZERO_IN;
            repeat (18) @(posedge clk);
            #1;
            @(negedge clk);
            bus.valid_s = 1'b0;
            drain();
        end

        // reset after five ROUND edges aborts the block
        @(negedge clk);
        bus.valid_s = 1'b1;
        bus.din = V_FULL_IN;
        @(posedge clk);
        #1;
        bus.valid_s = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        chk("abort_dout", bus.dout, 128'd0);
        chk("abort_flags", {bus.busy_s, bus.pre_ready_s, bus.ready_s}, 128'd0);
        @(negedge clk);
        reset = 1'b0;
        repeat (25) @(negedge clk);
        chk("abort_idle", 128'(bus.busy_s), 128'd0);
        send(V_KNOWN_IN, 1'b0, V_KNOWN_OUT);
        drain();

        chk("queue_empty", 128'(exp_q.size()), 128'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
